// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue controller sitting between an RV32 front end and a purely
//   combinational ALU. It accepts one instruction at a time, decodes the
//   R-type, I-type ALU and branch formats, drives the ALU operands and
//   operation for a single EXEC cycle, captures the ALU outputs and holds
//   them as a response until the consumer takes it. Illegal encodings skip
//   the ALU and are reported straight away.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid / in_ready         request handshake (ready only when idle)
//   instr, rs1_val, rs2_val     instruction word and source operands
//   alu_a, alu_b, alu_op        operands and operation presented to the ALU
//   alu_result, alu_flag        combinational ALU outputs
//   resp_valid / resp_ready     response handshake
//   resp_data, resp_flag,
//   resp_illegal                response payload
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_flag,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_flag,
  output logic        resp_illegal
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b01000;
  localparam logic [4:0] OP_SLL  = 5'b00001;
  localparam logic [4:0] OP_SLT  = 5'b00010;
  localparam logic [4:0] OP_SLTU = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SRA  = 5'b01101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b00111;
  localparam logic [4:0] OP_BEQ  = 5'b11000;
  localparam logic [4:0] OP_BNE  = 5'b11001;
  localparam logic [4:0] OP_BLT  = 5'b11100;
  localparam logic [4:0] OP_BGE  = 5'b11101;
  localparam logic [4:0] OP_BLTU = 5'b11110;
  localparam logic [4:0] OP_BGEU = 5'b11111;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [4:0]  alu_op_q, alu_op_d;
  logic        is_branch_q, is_branch_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_flag_q, resp_flag_d;
  logic        resp_illegal_q, resp_illegal_d;

  // Instruction fields and decode results for the word on the input port.
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] shamt;
  logic        dec_illegal;
  logic        dec_branch;
  logic [4:0]  dec_op;
  logic [31:0] dec_b;

  // Register specifiers are resolved upstream; only operand values arrive here.
  logic unused_bits;
  assign unused_bits = ^{instr[19:15], instr[11:7]};

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign shamt  = {27'b0, instr[24:20]};

  always_comb begin
    dec_illegal = 1'b0;
    dec_branch  = 1'b0;
    dec_op      = OP_ADD;
    dec_b       = rs2_val;
    case (opcode)
      OPC_R: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  dec_op = OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_op = OP_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_op = OP_SRA;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_I: begin
        dec_b = imm_i;
        case (funct3)
          3'b000: dec_op = OP_ADD;
          3'b010: dec_op = OP_SLT;
          3'b011: dec_op = OP_SLTU;
          3'b100: dec_op = OP_XOR;
          3'b110: dec_op = OP_OR;
          3'b111: dec_op = OP_AND;
          3'b001: begin
            // Upper immediate bits act as funct7 for shifts; only the shift
            // amount reaches the ALU.
            dec_b  = shamt;
            dec_op = OP_SLL;
            if (funct7 != F7_BASE) dec_illegal = 1'b1;
          end
          default: begin
            dec_b = shamt;
            if (funct7 == F7_BASE)     dec_op = OP_SRL;
            else if (funct7 == F7_ALT) dec_op = OP_SRA;
            else                       dec_illegal = 1'b1;
          end
        endcase
      end
      OPC_B: begin
        dec_branch = 1'b1;
        case (funct3)
          3'b000:  dec_op = OP_BEQ;
          3'b001:  dec_op = OP_BNE;
          3'b100:  dec_op = OP_BLT;
          3'b101:  dec_op = OP_BGE;
          3'b110:  dec_op = OP_BLTU;
          3'b111:  dec_op = OP_BGEU;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Next-state and datapath updates. ALU-facing registers load only on a
  // legal accept, so they stay put through RESP, IDLE and illegal requests.
  always_comb begin
    state_d        = state_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    is_branch_d    = is_branch_q;
    resp_data_d    = resp_data_q;
    resp_flag_d    = resp_flag_q;
    resp_illegal_d = resp_illegal_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (dec_illegal) begin
            state_d        = RESP;
            resp_illegal_d = 1'b1;
            resp_data_d    = 32'b0;
            resp_flag_d    = 1'b0;
          end else begin
            state_d        = EXEC;
            alu_a_d        = rs1_val;
            alu_b_d        = dec_b;
            alu_op_d       = dec_op;
            is_branch_d    = dec_branch;
            resp_illegal_d = 1'b0;
          end
        end
      end
      EXEC: begin
        // Branches report only the condition; arithmetic reports only data.
        resp_data_d = is_branch_q ? 32'b0 : alu_result;
        resp_flag_d = is_branch_q ? alu_flag : 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      alu_a_q        <= 32'b0;
      alu_b_q        <= 32'b0;
      alu_op_q       <= OP_ADD;
      is_branch_q    <= 1'b0;
      resp_data_q    <= 32'b0;
      resp_flag_q    <= 1'b0;
      resp_illegal_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      is_branch_q    <= is_branch_d;
      resp_data_q    <= resp_data_d;
      resp_flag_q    <= resp_flag_d;
      resp_illegal_q <= resp_illegal_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign resp_data    = resp_data_q;
  assign resp_flag    = resp_flag_q;
  assign resp_illegal = resp_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: directed cases, reset aborts and a random
// run, with a scoreboard fed by the driver and drained by a response monitor.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_flag;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_flag;
  logic        resp_illegal;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flag(alu_flag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_flag(resp_flag), .resp_illegal(resp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU. Non-branch ops raise the flag and branch ops return
  // nonzero data so the controller's forcing of unused fields is visible.
  always_comb begin
    alu_result = 32'b0;
    alu_flag   = 1'b1;
    case (alu_op)
      5'b00000: alu_result = alu_a + alu_b;
      5'b01000: alu_result = alu_a - alu_b;
      5'b00001: alu_result = alu_a << alu_b[4:0];
      5'b00010: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      5'b00011: alu_result = {31'b0, alu_a < alu_b};
      5'b00100: alu_result = alu_a ^ alu_b;
      5'b00101: alu_result = alu_a >> alu_b[4:0];
      5'b01101: alu_result = $signed(alu_a) >>> alu_b[4:0];
      5'b00110: alu_result = alu_a | alu_b;
      5'b00111: alu_result = alu_a & alu_b;
      default: begin
        alu_result = (alu_a - alu_b) | 32'h1;
        case (alu_op)
          5'b11000: alu_flag = (alu_a == alu_b);
          5'b11001: alu_flag = (alu_a != alu_b);
          5'b11100: alu_flag = ($signed(alu_a) < $signed(alu_b));
          5'b11101: alu_flag = ($signed(alu_a) >= $signed(alu_b));
          5'b11110: alu_flag = (alu_a < alu_b);
          5'b11111: alu_flag = (alu_a >= alu_b);
          default:  alu_flag = 1'b0;
        endcase
      end
    endcase
  end

  typedef struct {
    logic        ill;
    logic [31:0] data;
    logic        flag;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rr_random = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Instruction semantics straight from the RV32 definitions.
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] r1,
                                     input logic [31:0] r2);
    exp_t        e;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [4:0]  sh;
    f7 = ins[31:25];
    f3 = ins[14:12];
    imm = {{20{ins[31]}}, ins[31:20]};
    sh = ins[24:20];
    e.ill = 1'b0; e.data = 32'b0; e.flag = 1'b0; e.op = 5'b0; e.a = r1; e.b = r2;
    case (ins[6:0])
      7'b0110011: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: begin e.op = 5'b00000; e.data = r1 + r2; end
            3'd1: begin e.op = 5'b00001; e.data = r1 << r2[4:0]; end
            3'd2: begin e.op = 5'b00010; e.data = ($signed(r1) < $signed(r2)) ? 32'd1 : 32'd0; end
            3'd3: begin e.op = 5'b00011; e.data = (r1 < r2) ? 32'd1 : 32'd0; end
            3'd4: begin e.op = 5'b00100; e.data = r1 ^ r2; end
            3'd5: begin e.op = 5'b00101; e.data = r1 >> r2[4:0]; end
            3'd6: begin e.op = 5'b00110; e.data = r1 | r2; end
            default: begin e.op = 5'b00111; e.data = r1 & r2; end
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
          e.op = 5'b01000; e.data = r1 - r2;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
          e.op = 5'b01101; e.data = $signed(r1) >>> r2[4:0];
        end else e.ill = 1'b1;
      end
      7'b0010011: begin
        e.b = imm;
        case (f3)
          3'd0: begin e.op = 5'b00000; e.data = r1 + imm; end
          3'd2: begin e.op = 5'b00010; e.data = ($signed(r1) < $signed(imm)) ? 32'd1 : 32'd0; end
          3'd3: begin e.op = 5'b00011; e.data = (r1 < imm) ? 32'd1 : 32'd0; end
          3'd4: begin e.op = 5'b00100; e.data = r1 ^ imm; end
          3'd6: begin e.op = 5'b00110; e.data = r1 | imm; end
          3'd7: begin e.op = 5'b00111; e.data = r1 & imm; end
          3'd1: begin
            e.b = {27'b0, sh};
            if (f7 == 7'h00) begin e.op = 5'b00001; e.data = r1 << sh; end
            else e.ill = 1'b1;
          end
          default: begin
            e.b = {27'b0, sh};
            if (f7 == 7'h00)      begin e.op = 5'b00101; e.data = r1 >> sh; end
            else if (f7 == 7'h20) begin e.op = 5'b01101; e.data = $signed(r1) >>> sh; end
            else e.ill = 1'b1;
          end
        endcase
      end
      7'b1100011: begin
        case (f3)
          3'd0: begin e.op = 5'b11000; e.flag = (r1 == r2); end
          3'd1: begin e.op = 5'b11001; e.flag = (r1 != r2); end
          3'd4: begin e.op = 5'b11100; e.flag = ($signed(r1) < $signed(r2)); end
          3'd5: begin e.op = 5'b11101; e.flag = ($signed(r1) >= $signed(r2)); end
          3'd6: begin e.op = 5'b11110; e.flag = (r1 < r2); end
          3'd7: begin e.op = 5'b11111; e.flag = (r1 >= r2); end
          default: e.ill = 1'b1;
        endcase
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin e.data = 32'b0; e.flag = 1'b0; end
    return e;
  endfunction

  // Issue one request, check the ALU drive during EXEC and the latency.
  task automatic send(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    exp_t       e;
    int         lat;
    int         wait_c;
    logic [4:0] prev_op;
    e = ref_model(ins, r1, r2);
    @(negedge clk);
    wait_c = 0;
    while (!in_ready && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
      return;
    end
    prev_op  = alu_op;
    in_valid = 1'b1;
    instr    = ins;
    rs1_val  = r1;
    rs2_val  = r2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    instr    = $urandom;
    rs1_val  = $urandom;
    rs2_val  = $urandom;
    exp_q.push_back(e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
        if (e.ill) chk("alu_op_hold", {27'b0, alu_op}, {27'b0, prev_op});
        else begin
          chk("alu_op", {27'b0, alu_op}, {27'b0, e.op});
          chk("alu_a", alu_a, e.a);
          chk("alu_b", alu_b, e.b);
        end
      end
    end while (!resp_valid && lat < 10);
    chk("latency", lat, e.ill ? 32'd1 : 32'd2);
  endtask

  // Response monitor: each completed handshake is matched against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_illegal", {31'b0, resp_illegal}, {31'b0, e.ill});
        chk("resp_data", resp_data, e.data);
        chk("resp_flag", {31'b0, resp_flag}, {31'b0, e.flag});
      end
    end
  end

  // Random backpressure, driven just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_random) resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  f7;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 9);
    case ($urandom_range(0, 2))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    if (k < 4) begin
      w[6:0] = 7'b0110011;
      w[31:25] = f7;
    end else if (k < 7) begin
      w[6:0] = 7'b0010011;
      if (w[13:12] == 2'b01) w[31:25] = f7;
    end else if (k < 9) begin
      w[6:0] = 7'b1100011;
    end
    return w;
  endfunction

  logic [31:0] held;
  int          drain;

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    instr      = 32'b0;
    rs1_val    = 32'b0;
    rs2_val    = 32'b0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_flag", {31'b0, resp_flag}, 32'd0);
    chk("rst_resp_illegal", {31'b0, resp_illegal}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", {27'b0, alu_op}, 32'd0);
    rst_n = 1'b1;
    resp_ready = 1'b1;

    send(32'h002081B3, 32'd5, 32'd7);
    send(32'h402081B3, 32'd10, 32'd3);
    send(32'h0020C063, 32'hFFFFFFFF, 32'd1);
    send(32'hFFF00093, 32'd0, 32'd0);
    send(32'h00000000, 32'd1, 32'd2);

    // Backpressure: payload must hold and no new request may be taken.
    @(posedge clk);
    #1 resp_ready = 1'b0;
    send(32'h002081B3, 32'd100, 32'd23);
    held = resp_data;
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_data", resp_data, held);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_resp_in_ready", {31'b0, in_ready}, 32'd1);
    chk("post_resp_valid", {31'b0, resp_valid}, 32'd0);

    // Reset while in EXEC: the transaction vanishes.
    @(negedge clk);
    in_valid = 1'b1;
    instr    = 32'h002081B3;
    rs1_val  = 32'd1;
    rs2_val  = 32'd2;
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("exec_rst_valid", {31'b0, resp_valid}, 32'd0);
      chk("exec_rst_in_ready", {31'b0, in_ready}, 32'd1);
    end
    chk("exec_rst_alu_op", {27'b0, alu_op}, 32'd0);

    // Reset while a response is pending.
    resp_ready = 1'b0;
    send(32'h0020C063, 32'd3, 32'd4);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    resp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("resp_rst_valid", {31'b0, resp_valid}, 32'd0);
    end
    chk("resp_rst_data", resp_data, 32'd0);

    rr_random = 1'b1;
    for (int i = 0; i < 150; i++) send(rand_instr(), rand_operand(), rand_operand());

    drain = 0;
    while (exp_q.size() != 0 && drain < 200) begin
      @(negedge clk);
      drain++;
    end
    chk("drain", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have no parameters; ALUOp encodings are fixed: ADD 00000, SUB 01000, SLL 00001, SLT 00010, SLTU 00011, XOR 00100, SRL 00101, SRA 01101, OR 00110, AND 00111, BEQ 11000, BNE 11001, BLT 11100, BGE 11101, BLTU 11110, BGEU 11111.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 in_valid  in  1  instruction request valid.
REQ-005 in_ready  out  1  block can accept a request.
REQ-006 instr  in  32  RV32 instruction word.
REQ-007 rs1_val, rs2_val  in  32 each  source operand values.
REQ-008 alu_a, alu_b  out  32 each  operands driven to the ALU.
REQ-009 alu_op  out  5  ALU operation code.
REQ-010 alu_result  in  32, alu_flag  in  1  combinational ALU outputs.
REQ-011 resp_valid  out  1, resp_ready  in  1  response handshake.
REQ-012 resp_data  out  32, resp_flag  out  1, resp_illegal  out  1  response payload.

Function
REQ-013 The FSM SHALL have states IDLE, EXEC, RESP; in_ready SHALL be 1 only in IDLE.
REQ-014 Accept on in_valid&&in_ready: latch instr fields, rs1_val, rs2_val; decode registered.
REQ-015 Opcode 0110011 (R): alu_a=rs1, alu_b=rs2; funct3/funct7 map to ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; funct7 0100000 legal only with funct3 000/101; any other funct7 illegal.
REQ-016 Opcode 0010011 (I): alu_b=sign-extended instr[31:20]; funct3 000 always ADD; shifts use alu_b=zero-extended instr[24:20], funct7 0000000 (SLLI/SRLI) or 0100000 (SRAI only); others illegal.
REQ-017 Opcode 1100011 (B): alu_a=rs1, alu_b=rs2; funct3 000/001/100/101/110/111 -> BEQ/BNE/BLT/BGE/BLTU/BGEU; 010/011 illegal.
REQ-018 Any other opcode SHALL be illegal.
REQ-019 Legal accept: IDLE->EXEC; in EXEC alu_a/alu_b/alu_op SHALL be stable for exactly one cycle; at that edge capture alu_result->resp_data, alu_flag->resp_flag, go to RESP.
REQ-020 Illegal accept: IDLE->RESP directly with resp_illegal=1, resp_data=0, resp_flag=0; alu_op unchanged.
REQ-021 For R/I ops resp_flag SHALL be forced 0; for B ops resp_data SHALL be forced 0.
REQ-022 resp_valid SHALL be 1 exactly in RESP; payload SHALL hold stable until resp_valid&&resp_ready, then RESP->IDLE.
REQ-023 Latency: legal request accepted at edge N -> resp_valid at N+2; illegal -> N+1.
REQ-024 No new request SHALL be accepted in the cycle the response completes (in_ready rises the cycle after).
REQ-025 Outside EXEC, alu_a, alu_b, alu_op SHALL hold last values (no glitch toggling).

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, in_ready=1 next cycle, resp_valid=0, resp_data=0, resp_flag=0, resp_illegal=0, alu_a=0, alu_b=0, alu_op=00000.
REQ-027 Reset in EXEC or RESP SHALL abort the transaction; no response is ever issued for it.

Verification
REQ-028 instr 0x002081B3, rs1=5, rs2=7 -> alu_op 00000, resp_data 12, resp_flag 0, resp_valid 2 cycles after accept.
REQ-029 instr 0x402081B3, rs1=10, rs2=3 -> alu_op 01000, resp_data 7.
REQ-030 instr 0x0020C063, rs1=0xFFFFFFFF, rs2=1 -> alu_op 11100, resp_flag 1, resp_data 0.
REQ-031 instr 0xFFF00093, rs1=0 -> alu_b 0xFFFFFFFF, resp_data 0xFFFFFFFF.
REQ-032 instr 0x00000000 -> resp_illegal 1 one cycle after accept; then legal request with resp_ready low 3 cycles -> payload stable, in_ready 0 throughout.
REQ-033 rst_n low during EXEC -> resp_valid never asserts, in_ready 1 after reset.
